// File: rtl/trivium_ks_ctrl.sv
// Sequencer for a bit-serial Trivium core: key/IV load, warm-up, then keystream words over valid/ready.
// Define TRIV_XOR_EN to add a din stream that is XORed into each keystream word at transfer.
module trivium_ks_ctrl #(
  parameter int WARMUP = 1152,
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic [79:0]       Kin,
  input  logic [79:0]       IVin,
  input  logic              Krdy,
  input  logic              Drdy,
  input  logic [LEN_W-1:0]  len,
  output logic              BSY,
  output logic              Kvld,
  output logic              Dvld,
  output logic              core_load,
  output logic [79:0]       core_key,
  output logic [79:0]       core_iv,
  output logic              core_step,
  input  logic              core_z,
`ifdef TRIV_XOR_EN
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
`endif
  output logic [WORD_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready
);

  localparam int WC_W = $clog2(WARMUP + 1);
  localparam int BC_W = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, DRAIN} state_t;

  state_t            state;
  logic [WC_W-1:0]   warm_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  len_reg;
  logic [WORD_W-1:0] pack;
  logic              pack_full;
  logic              out_free;
  logic              xfer;
  logic [WORD_W-1:0] xfer_word;

  assign pack_full = (bit_cnt == BC_W'(WORD_W));
  assign out_free  = !ks_valid || ks_ready;

`ifdef TRIV_XOR_EN
  assign xfer      = EN && (state == GEN) && pack_full && out_free && din_valid;
  assign xfer_word = pack ^ din;
  assign din_ready = xfer;
`else
  assign xfer      = EN && (state == GEN) && pack_full && out_free;
  assign xfer_word = pack;
`endif

  // Core strobes are decoded from state so EN=0 stops the core in the same cycle.
  assign core_load = EN && (state == LOAD);
  assign core_step = EN && ((state == WARM) || ((state == GEN) && !pack_full));
  assign BSY       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= IDLE;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len_reg  <= '0;
      pack     <= '0;
      ks_data  <= '0;
      ks_valid <= 1'b0;
      core_key <= '0;
      core_iv  <= '0;
      Kvld     <= 1'b0;
      Dvld     <= 1'b0;
    end else if (EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      if (ks_valid && ks_ready) begin
        ks_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (Krdy) begin
            core_key <= Kin;
            core_iv  <= IVin;
            state    <= LOAD;
          end else if (Drdy) begin
            len_reg  <= len;
            word_cnt <= '0;
            if (len == '0) begin
              Dvld <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end
        LOAD: begin
          warm_cnt <= '0;
          state    <= WARM;
        end
        WARM: begin
          if (warm_cnt == WC_W'(WARMUP - 1)) begin
            warm_cnt <= '0;
            Kvld     <= 1'b1;
            state    <= IDLE;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        GEN: begin
          if (!pack_full) begin
            // shift right so the oldest bit ends up in bit 0
            pack    <= {core_z, pack[WORD_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (xfer) begin
            ks_data  <= xfer_word;
            ks_valid <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == len_reg - 1'b1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (ks_valid && ks_ready) begin
            Dvld     <= 1'b1;
            word_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Bench for trivium_ks_ctrl: a behavioural Trivium core drives core_z; words are checked against a software keystream.
`timescale 1ns/1ps
module tb_trivium_ks_ctrl;
  localparam int WARMUP = 1152;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              EN = 1'b0;
  logic [79:0]       Kin = '0;
  logic [79:0]       IVin = '0;
  logic              Krdy = 1'b0;
  logic              Drdy = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              BSY, Kvld, Dvld, core_load, core_step, core_z, ks_valid;
  logic [79:0]       core_key, core_iv;
  logic [WORD_W-1:0] ks_data;
  logic              ks_ready = 1'b0;
`ifdef TRIV_XOR_EN
  logic [WORD_W-1:0] din = '0;
  logic              din_valid = 1'b1;
  logic              din_ready;
`endif

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] got_q[$];
  logic [WORD_W-1:0] ref_q[$];
  logic [288:1]      core_s = '0;
  logic [288:1]      ref_s = '0;

  always #5 CLK = ~CLK;

  trivium_ks_ctrl #(.WARMUP(WARMUP), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Kin(Kin), .IVin(IVin), .Krdy(Krdy), .Drdy(Drdy),
    .len(len), .BSY(BSY), .Kvld(Kvld), .Dvld(Dvld), .core_load(core_load),
    .core_key(core_key), .core_iv(core_iv), .core_step(core_step), .core_z(core_z),
`ifdef TRIV_XOR_EN
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
`endif
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready)
  );

  function automatic logic [288:1] triv_init(input logic [79:0] key, input logic [79:0] iv);
    logic [288:1] s;
    s = '0;
    s[80:1] = key;
    s[173:94] = iv;
    s[288:286] = 3'b111;
    return s;
  endfunction

  function automatic logic triv_z(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] triv_next(input logic [288:1] s);
    logic [288:1] n;
    logic t1, t2, t3;
    t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n[93:1] = {s[92:1], t3};
    n[177:94] = {s[176:94], t1};
    n[288:178] = {s[287:178], t2};
    return n;
  endfunction

  // Environment: the Trivium datapath the controller sequences.
  always @(posedge CLK) begin
    if (core_load) core_s <= triv_init(core_key, core_iv);
    else if (core_step) core_s <= triv_next(core_s);
  end
  assign core_z = triv_z(core_s);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_load(input logic [79:0] key, input logic [79:0] iv);
    ref_s = triv_init(key, iv);
    repeat (WARMUP) ref_s = triv_next(ref_s);
  endtask

  task automatic ref_word(output logic [WORD_W-1:0] w);
    for (int i = 0; i < WORD_W; i++) begin
      w[i] = triv_z(ref_s);
      ref_s = triv_next(ref_s);
    end
  endtask

  task automatic do_load(input logic [79:0] key, input logic [79:0] iv, input bit with_drdy);
    int loads, load_cyc, steps, kvld_cyc, kvld_n, last_bsy, vld_n;
    loads = 0; load_cyc = -1; steps = 0; kvld_cyc = -1; kvld_n = 0; last_bsy = -1; vld_n = 0;
    @(negedge CLK);
    Kin = key; IVin = iv; Krdy = 1'b1; Drdy = with_drdy; len = 16'd3;
    @(negedge CLK);
    Krdy = 1'b0; Drdy = 1'b0;
    for (int c = 1; c <= WARMUP + 6; c++) begin
      if (core_load) begin loads++; load_cyc = c; end
      if (core_step) steps++;
      if (BSY) last_bsy = c;
      if (ks_valid) vld_n++;
      if (Kvld) begin kvld_n++; if (kvld_cyc < 0) kvld_cyc = c; end
      if (c == 1) begin
        check("core_key", core_key, key);
        check("core_iv", core_iv, iv);
      end
      Drdy = (c == 10);  // request during warm-up must be dropped
      @(negedge CLK);
    end
    Drdy = 1'b0;
    check("load_pulses", loads, 1);
    check("load_cycle", load_cyc, 1);
    check("warm_steps", steps, WARMUP);
    check("kvld_cycle", kvld_cyc, WARMUP + 2);
    check("kvld_pulses", kvld_n, 1);
    check("bsy_last", last_bsy, WARMUP + 1);
    check("no_valid_in_load", vld_n, 0);
    $display("load key=%h iv=%h drdy=%0d kvld@%0d steps=%0d", key, iv, with_drdy, kvld_cyc, steps);
    ref_load(key, iv);
  endtask

  task automatic do_req(input int n, input int mode, input int en_at, input int rst_at,
                        output int done_cyc, output int steps);
    logic [WORD_W-1:0] exp_w, prev_data;
    bit prev_hold, stall_started;
    int got, stall_left, stall_steps, unstable, leaked;
    prev_hold = 0; stall_started = 0; got = 0; stall_left = 0; stall_steps = 0;
    unstable = 0; leaked = 0; done_cyc = -1; steps = 0; prev_data = '0;
    @(negedge CLK);
    len = LEN_W'(n); Drdy = 1'b1; ks_ready = 1'b0;
    @(negedge CLK);
    Drdy = 1'b0;
    for (int c = 1; c <= 40 * n + 300 && done_cyc < 0; c++) begin
      EN = !(en_at > 0 && c >= en_at && c < en_at + 10);
      case (mode)
        0: ks_ready = 1'b1;
        1: ks_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stall_started && ks_valid) begin stall_started = 1; stall_left = 100; end
          ks_ready = (stall_left == 0);
        end
      endcase
      #1;
      if (core_step) begin steps++; if (stall_left > 0) stall_steps++; end
      if (stall_left > 0) stall_left--;
      if (prev_hold && !(ks_valid && ks_data === prev_data)) unstable++;
      if (c == rst_at) begin
        RSTn = 1'b0;
        @(negedge CLK);
        check("rst_bsy", BSY, 1'b0);
        check("rst_valid", ks_valid, 1'b0);
        check("rst_data", ks_data, '0);
        check("rst_step", core_step, 1'b0);
        check("rst_key", core_key, '0);
        check("rst_dvld", Dvld, 1'b0);
        RSTn = 1'b1;
        ks_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
          @(negedge CLK);
          if (ks_valid || BSY || core_step) leaked++;
        end
        check("rst_no_partial", leaked, 0);
        ks_ready = 1'b0;
        $display("req len=%0d reset at cycle %0d words=%0d", n, c, got);
        return;
      end
      if (EN && ks_valid && ks_ready) begin
        ref_word(exp_w);
        check("word", ks_data, exp_w);
        got_q.push_back(ks_data);
        got++;
      end
      prev_hold = ks_valid && !(EN && ks_ready);
      prev_data = ks_data;
      if (Dvld) done_cyc = c;
      @(negedge CLK);
    end
    ks_ready = 1'b0; EN = 1'b1;
    check("done_seen", done_cyc > 0, 1'b1);
    check("word_count", got, n);
    check("stable_hold", unstable, 0);
    check("valid_after_done", ks_valid, 1'b0);
    if (mode == 2) check("stall_steps", stall_steps, WORD_W);
    $display("req len=%0d mode=%0d words=%0d dvld@%0d steps=%0d", n, mode, got, done_cyc, steps);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc, steps;
    logic [79:0] k, iv;
    logic [WORD_W-1:0] saved[$];

    EN = 1'b1; RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_bsy", BSY, 1'b0);
    check("reset_kvld", Kvld, 1'b0);
    check("reset_dvld", Dvld, 1'b0);
    check("reset_load", core_load, 1'b0);
    check("reset_step", core_step, 1'b0);
    check("reset_valid", ks_valid, 1'b0);
    check("reset_data", ks_data, '0);
    check("reset_key", {core_key, core_iv}, '0);
    RSTn = 1'b1;

    // zero key/IV, with a Drdy during warm-up that must be ignored
    do_load('0, '0, 1'b0);
    do_req(4, 0, 0, 0, done_cyc, steps);
    check("len4_dvld_cycle", done_cyc, 4 * (WORD_W + 1) + 2);
    check("len4_steps", steps, 4 * WORD_W);

    do_req(3, 2, 0, 0, done_cyc, steps);
    check("bp_steps", steps, 3 * WORD_W);

    do_req(0, 0, 0, 0, done_cyc, steps);
    check("len0_dvld_cycle", done_cyc, 1);
    check("len0_steps", steps, 0);

    // continuation: one len=4 request versus two len=2 requests from the same key
    k = {$urandom(), $urandom(), 16'($urandom())};
    iv = {$urandom(), $urandom(), 16'($urandom())};
    do_load(k, iv, 1'b1);
    got_q.delete();
    do_req(4, 1, 0, 0, done_cyc, steps);
    saved = got_q;
    do_load(k, iv, 1'b0);
    got_q.delete();
    do_req(2, 1, 0, 0, done_cyc, steps);
    do_req(2, 1, 0, 0, done_cyc, steps);
    check("cont_len", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size() && i < saved.size(); i++)
      check("cont_word", got_q[i], saved[i]);

    do_req(2, 0, 10, 0, done_cyc, steps);
    check("en_dvld_cycle", done_cyc, 2 * (WORD_W + 1) + 2 + 10);
    check("en_steps", steps, 2 * WORD_W);

    for (int r = 0; r < 3; r++) begin
      do_req($urandom_range(1, 5), 1, 0, 0, done_cyc, steps);
    end

    do_req(3, 0, 0, 45, done_cyc, steps);

    k = {$urandom(), $urandom(), 16'($urandom())};
    iv = {$urandom(), $urandom(), 16'($urandom())};
    do_load(k, iv, 1'b0);
    do_req($urandom_range(1, 4), 1, 0, 0, done_cyc, steps);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
